ps2_host_tx: RTL and testbench

// - Host-to-device PS/2 transmitter: the send side of the keyboard link, complementing the scan-code receiver.
// - Sends one command byte, e.g. 0xED (set LEDs) or 0xFF (reset), to the keyboard on PS2_CLK/PS2_DAT.
// - Drives both lines open-collector. Top level: PS2_CLK = ps2_clk_oe ? 1'b0 : 1'bz (same form for PS2_DAT).

---
 rtl/ps2_host_tx.sv | 152 +++++++++++++++
 tb/tb_ps2_host_tx.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter sending one command byte to the keyboard.
// Ports:
//   CLOCK_50                  system clock (50 MHz)
//   AUD_DACLRCK               asynchronous active-low reset
//   i_valid, i_data, o_ready  command byte handshake; accepted when i_valid & o_ready
//   o_busy                    frame in progress
//   o_done                    one-cycle pulse: frame ACKed and lines idle
//   o_err                     one-cycle pulse: timeout or missing ACK
//   ps2_clk_i, ps2_dat_i      raw PS2_CLK / PS2_DAT pin values
//   ps2_clk_oe, ps2_dat_oe    1 = pull the line low (pin = oe ? 0 : z)
// Build option PS2_TX_RETRY_EN: a failed frame is resent up to MAX_RETRY times before o_err.
module ps2_host_tx #(
    parameter int INHIBIT_CYC = 5000,
    parameter int START_CYC   = 10,
    parameter int TIMEOUT_CYC = 750000
`ifdef PS2_TX_RETRY_EN
    ,
    parameter int MAX_RETRY   = 2
`endif
) (
    input  logic       CLOCK_50,
    input  logic       AUD_DACLRCK,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);
    typedef enum logic [2:0] {IDLE, INHIBIT, START, SEND, ACK, WAIT_IDLE, DONE, ERR} state_t;
    localparam int CW = $clog2(INHIBIT_CYC + START_CYC + TIMEOUT_CYC);
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [8:0]    sh_q, sh_d;
    logic          dat_oe_q, dat_oe_d;
    logic [1:0]    clk_s_q, dat_s_q;
    logic          clk_prev_q;
    logic          fall, watchdog, fail;
`ifdef PS2_TX_RETRY_EN
    localparam int RW = $clog2(MAX_RETRY + 2);
    logic [RW-1:0] retry_q, retry_d;
    logic [8:0]    frame_q, frame_d;
`endif

    assign fall     = clk_prev_q & ~clk_s_q[1];
    assign watchdog = (state_q == SEND || state_q == ACK || state_q == WAIT_IDLE) &&
                      cnt_q == CW'(TIMEOUT_CYC - 1);
    assign fail     = watchdog | (state_q == ACK && fall && dat_s_q[1]);

    assign o_ready    = state_q == IDLE;
    assign o_busy     = state_q != IDLE;
    assign o_done     = state_q == DONE;
    assign o_err      = state_q == ERR;
    assign ps2_clk_oe = state_q == INHIBIT || state_q == START;
    assign ps2_dat_oe = dat_oe_q;

    // Synchronisers reset to 1 (idle bus) so no false fall is seen after reset.
    always_ff @(posedge CLOCK_50 or negedge AUD_DACLRCK) begin
        if (!AUD_DACLRCK) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            sh_q       <= '0;
            dat_oe_q   <= 1'b0;
            clk_s_q    <= 2'b11;
            dat_s_q    <= 2'b11;
            clk_prev_q <= 1'b1;
`ifdef PS2_TX_RETRY_EN
            retry_q    <= '0;
            frame_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            sh_q       <= sh_d;
            dat_oe_q   <= dat_oe_d;
            clk_s_q    <= {clk_s_q[0], ps2_clk_i};
            dat_s_q    <= {dat_s_q[0], ps2_dat_i};
            clk_prev_q <= clk_s_q[1];
`ifdef PS2_TX_RETRY_EN
            retry_q    <= retry_d;
            frame_q    <= frame_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        bit_d    = bit_q;
        sh_d     = sh_q;
        dat_oe_d = dat_oe_q;
`ifdef PS2_TX_RETRY_EN
        retry_d  = retry_q;
        frame_d  = frame_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (i_valid) begin
                    state_d = INHIBIT;
                    sh_d    = {~^i_data, i_data};
`ifdef PS2_TX_RETRY_EN
                    frame_d = {~^i_data, i_data};
                    retry_d = '0;
`endif
                end
            end
            INHIBIT: if (cnt_q == CW'(INHIBIT_CYC - 1)) begin
                state_d  = START;
                cnt_d    = '0;
                dat_oe_d = 1'b1;
            end
            START: if (cnt_q == CW'(START_CYC - 1)) begin
                state_d = SEND;
                cnt_d   = '0;
                bit_d   = '0;
            end
            // Ones shift in behind the payload, so the 10th fall releases dat as the stop bit.
            SEND: if (fall) begin
                dat_oe_d = ~sh_q[0];
                sh_d     = {1'b1, sh_q[8:1]};
                bit_d    = bit_q + 1'b1;
                if (bit_q == 4'd9) state_d = ACK;
            end
            ACK: if (fall && !dat_s_q[1]) state_d = WAIT_IDLE;
            WAIT_IDLE: if (clk_s_q[1] && dat_s_q[1]) state_d = DONE;
            default: begin
                state_d  = IDLE;
                dat_oe_d = 1'b0;
            end
        endcase
        if (fail) begin
            dat_oe_d = 1'b0;
            state_d  = ERR;
`ifdef PS2_TX_RETRY_EN
            if (retry_q < RW'(MAX_RETRY)) begin
                state_d = INHIBIT;
                retry_d = retry_q + 1'b1;
                cnt_d   = '0;
                sh_d    = frame_q;
            end
`endif
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with a PS/2 device model and a bit scoreboard.
module tb_ps2_host_tx;
    localparam int INH = 5000;
    localparam int STC = 10;
    localparam int TMO = 1000;
    localparam int H   = 20;
`ifdef PS2_TX_RETRY_EN
    localparam int ATT = 3;
`else
    localparam int ATT = 1;
`endif

    logic       CLOCK_50 = 1'b0;
    logic       AUD_DACLRCK = 1'b0;
    logic       i_valid = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic       o_ready, o_busy, o_done, o_err, ps2_clk_oe, ps2_dat_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic       clk_line, dat_line;
    logic       exp_q[$];
    int         n_assert = 0;
    int         n_fail = 0;
    int         done_n = 0;
    int         err_n = 0;

    assign clk_line = ~ps2_clk_oe & ~dev_clk_low;
    assign dat_line = ~ps2_dat_oe & ~dev_dat_low;

    always #10 CLOCK_50 = ~CLOCK_50;

    ps2_host_tx #(.INHIBIT_CYC(INH), .START_CYC(STC), .TIMEOUT_CYC(TMO)) dut (
        .CLOCK_50(CLOCK_50), .AUD_DACLRCK(AUD_DACLRCK),
        .i_valid(i_valid), .i_data(i_data), .o_ready(o_ready), .o_busy(o_busy),
        .o_done(o_done), .o_err(o_err), .ps2_clk_i(clk_line), .ps2_dat_i(dat_line),
        .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe)
    );

    always @(negedge CLOCK_50) begin
        if (o_done === 1'b1) done_n++;
        if (o_err === 1'b1) err_n++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(b[i]);
            ones += int'(b[i]);
        end
        exp_q.push_back((ones % 2) == 0);
        exp_q.push_back(1'b1);
    endtask

    task automatic send(input logic [7:0] b, input bit push);
        @(negedge CLOCK_50);
        i_valid = 1'b1;
        i_data  = b;
        if (push) push_frame(b);
        @(negedge CLOCK_50);
        i_valid = 1'b0;
    endtask

    task automatic wait_release(output int hi, output int rise, input bit poke);
        hi = 0;
        rise = -1;
        while (ps2_clk_oe === 1'b1 && hi < 8000) begin
            if (ps2_dat_oe === 1'b1 && rise < 0) rise = hi;
            if (poke && hi == 100) begin i_valid = 1'b1; i_data = 8'h55; end
            if (poke && hi == 101) i_valid = 1'b0;
            hi++;
            @(negedge CLOCK_50);
        end
    endtask

    task automatic device(input int npulse, input bit ack);
        logic e;
        repeat (H) @(negedge CLOCK_50);
        for (int i = 0; i < npulse; i++) begin
            if (i == 10 && ack) dev_dat_low = 1'b1;
            dev_clk_low = 1'b1;
            repeat (H) @(negedge CLOCK_50);
            dev_clk_low = 1'b0;
            if (i < 10) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
                check($sformatf("bit%0d", i), dat_line, e);
            end
            repeat (H) @(negedge CLOCK_50);
        end
        dev_dat_low = 1'b0;
    endtask

    task automatic good_frame(input logic [7:0] b, input bit poke);
        int d0, e0, hi, rise;
        d0 = done_n;
        e0 = err_n;
        send(b, 1'b1);
        check("ready_after_accept", o_ready, 0);
        check("busy_after_accept", o_busy, 1);
        wait_release(hi, rise, poke);
        check("clk_oe_cycles", hi, INH + STC);
        check("dat_oe_rise", rise, INH);
        device(11, 1'b1);
        repeat (50) @(negedge CLOCK_50);
        check("done_pulses", done_n - d0, 1);
        check("err_pulses", err_n - e0, 0);
        check("ready_idle", o_ready, 1);
        check("clk_oe_idle", ps2_clk_oe, 0);
    endtask

    initial begin
        int d0, e0, hi, rise, c;
        repeat (3) @(negedge CLOCK_50);
        check("rst_ready", o_ready, 1);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_err", o_err, 0);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_dat_oe", ps2_dat_oe, 0);
        AUD_DACLRCK = 1'b1;
        repeat (3) @(negedge CLOCK_50);

        good_frame(8'hED, 1'b1);
        good_frame(8'h01, 1'b0);
        good_frame(8'hFF, 1'b0);
        good_frame(8'h00, 1'b0);

        d0 = done_n;
        e0 = err_n;
        send(8'hA5, 1'b0);
        for (int a = 0; a < ATT; a++) begin
            push_frame(8'hA5);
            wait_release(hi, rise, 1'b0);
            if (a == 0) check("nack_clk_oe_cycles", hi, INH + STC);
            device(11, 1'b0);
        end
        repeat (50) @(negedge CLOCK_50);
        check("nack_done_pulses", done_n - d0, 0);
        check("nack_err_pulses", err_n - e0, 1);
        check("nack_ready", o_ready, 1);

        d0 = done_n;
        e0 = err_n;
        send(8'h42, 1'b0);
        for (int a = 0; a < ATT; a++) begin
            wait_release(hi, rise, 1'b0);
            check("tmo_clk_oe_cycles", hi, INH + STC);
            c = 0;
            while (o_err !== 1'b1 && ps2_clk_oe !== 1'b1 && c < TMO + 100) begin
                @(negedge CLOCK_50);
                c++;
            end
            check("tmo_cycles", c, TMO);
            check("tmo_err", o_err, (a == ATT - 1) ? 1 : 0);
        end
        @(negedge CLOCK_50);
        check("tmo_clk_oe_after", ps2_clk_oe, 0);
        check("tmo_dat_oe_after", ps2_dat_oe, 0);
        check("tmo_err_pulses", err_n - e0, 1);
        check("tmo_done_pulses", done_n - d0, 0);

        d0 = done_n;
        e0 = err_n;
        send(8'h0F, 1'b1);
        wait_release(hi, rise, 1'b0);
        device(4, 1'b1);
        dev_clk_low = 1'b1;
        repeat (10) @(negedge CLOCK_50);
        check("bit4_dat_oe", ps2_dat_oe, 1);
        AUD_DACLRCK = 1'b0;
        #1;
        check("rst_mid_dat_oe", ps2_dat_oe, 0);
        check("rst_mid_clk_oe", ps2_clk_oe, 0);
        dev_clk_low = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge CLOCK_50);
        AUD_DACLRCK = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        check("rst_mid_ready", o_ready, 1);
        check("rst_mid_no_pulse", (done_n - d0) + (err_n - e0), 0);

        good_frame(8'hF4, 1'b0);
        check("sb_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
